// File: rtl/bulls_cows_core.sv
// Bulls & Cows game engine: confirm-button conditioning, round state machine,
// scoring and decode of the 7-segment digit array and status LEDs.
module bulls_cows_core #(
    parameter int MAX_ATTEMPTS = 10,
    parameter int ERR_CYCLES   = 100_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             confirma,
    input  logic [15:0]      SW,
    output logic [15:0]      LED,
    output logic [7:0][3:0]  displaysResult
);

    localparam logic [2:0] S_SECRET = 3'd0;
    localparam logic [2:0] S_GUESS  = 3'd1;
    localparam logic [2:0] S_CALC   = 3'd2;
    localparam logic [2:0] S_ERR    = 3'd3;
    localparam logic [2:0] S_WIN    = 3'd4;
    localparam logic [2:0] S_LOSE   = 3'd5;

    localparam int ERR_W = $clog2(ERR_CYCLES + 1);

    logic [2:0]       state;
    logic [2:0]       ret_state;
    logic [15:0]      secret;
    logic [15:0]      guess;
    logic [2:0]       bulls;
    logic [2:0]       cows;
    logic [3:0]       attempts;
    logic [ERR_W-1:0] err_timer;
    logic             cfm_p0;
    logic             cfm_p1;
    logic             cfm_p2;
    logic             cfm;
    logic             sw_valid;
    logic [2:0]       calc_bulls;
    logic [2:0]       calc_cows;
    logic [3:0]       att_next;
    logic [3:0]       att_tens;
    logic [3:0]       att_units;

    function automatic logic digits_distinct(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [2:0] count_bulls(input logic [15:0] s, input logic [15:0] g);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++)
            if (g[4*i +: 4] == s[4*i +: 4]) n = n + 3'd1;
        return n;
    endfunction

    function automatic logic [2:0] count_cows(input logic [15:0] s, input logic [15:0] g);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && g[4*i +: 4] == s[4*j +: 4]) n = n + 3'd1;
        return n;
    endfunction

    function automatic logic [3:0] thermo(input logic [2:0] n);
        case (n)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    // Button path: two synchronizer flops, then a third flop for edge detection
    assign cfm        = cfm_p1 & ~cfm_p2;
    assign sw_valid   = digits_distinct(SW);
    assign calc_bulls = count_bulls(secret, guess);
    assign calc_cows  = count_cows(secret, guess);
    assign att_next   = attempts + 4'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_SECRET;
            ret_state <= S_SECRET;
            secret    <= '0;
            guess     <= '0;
            bulls     <= '0;
            cows      <= '0;
            attempts  <= '0;
            err_timer <= '0;
            cfm_p0    <= 1'b0;
            cfm_p1    <= 1'b0;
            cfm_p2    <= 1'b0;
        end else begin
            cfm_p0 <= confirma;
            cfm_p1 <= cfm_p0;
            cfm_p2 <= cfm_p1;
            case (state)
                S_SECRET: if (cfm) begin
                    if (sw_valid) begin
                        secret   <= SW;
                        guess    <= '0;
                        bulls    <= '0;
                        cows     <= '0;
                        attempts <= '0;
                        state    <= S_GUESS;
                    end else begin
                        ret_state <= S_SECRET;
                        err_timer <= '0;
                        state     <= S_ERR;
                    end
                end
                S_GUESS: if (cfm) begin
                    if (sw_valid) begin
                        guess <= SW;
                        state <= S_CALC;
                    end else begin
                        ret_state <= S_GUESS;
                        err_timer <= '0;
                        state     <= S_ERR;
                    end
                end
                S_CALC: begin
                    bulls    <= calc_bulls;
                    cows     <= calc_cows;
                    attempts <= att_next;
                    // A full match wins even on the last allowed attempt
                    if (calc_bulls == 3'd4)
                        state <= S_WIN;
                    else if (att_next == 4'(MAX_ATTEMPTS))
                        state <= S_LOSE;
                    else
                        state <= S_GUESS;
                end
                S_ERR: begin
                    if (err_timer == ERR_W'(ERR_CYCLES - 1)) begin
                        err_timer <= '0;
                        state     <= ret_state;
                    end else begin
                        err_timer <= err_timer + ERR_W'(1);
                    end
                end
                S_WIN, S_LOSE: if (cfm) begin
                    secret   <= '0;
                    guess    <= '0;
                    bulls    <= '0;
                    cows     <= '0;
                    attempts <= '0;
                    state    <= S_SECRET;
                end
                default: state <= S_SECRET;
            endcase
        end
    end

    // Output decode depends on registered state only
    always_comb begin
        att_tens  = (attempts >= 4'd10) ? 4'd1 : 4'd0;
        att_units = (attempts >= 4'd10) ? attempts - 4'd10 : attempts;

        LED       = '0;
        LED[15]   = (state == S_SECRET);
        LED[14]   = (state == S_GUESS) || (state == S_CALC);
        LED[13]   = (state == S_WIN);
        LED[12]   = (state == S_LOSE);
        LED[11]   = (state == S_ERR);
        LED[7:4]  = thermo(cows);
        LED[3:0]  = thermo(bulls);

        displaysResult[7] = guess[15:12];
        displaysResult[6] = guess[11:8];
        displaysResult[5] = guess[7:4];
        displaysResult[4] = guess[3:0];
        displaysResult[3] = att_tens;
        displaysResult[2] = att_units;
        displaysResult[1] = {1'b0, bulls};
        displaysResult[0] = {1'b0, cows};
    end

endmodule

// File: tb/tb_bulls_cows_core.sv
// Directed bench for bulls_cows_core with a reference scoring model and an
// expected-result queue popped after each button press settles.
module tb_bulls_cows_core;

    localparam int MAXA = 12;
    localparam int ERRC = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            confirma = 1'b0;
    logic [15:0]     SW = 16'h0000;
    logic [15:0]     LED;
    logic [7:0][3:0] displaysResult;
    logic [31:0]     disp_flat;

    typedef struct {
        string       tag;
        logic [15:0] led;
        logic [31:0] disp;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          attempts_m = 0;
    logic [15:0] secret_m = 16'h0000;
    logic [15:0] last_g = 16'h0000;
    int          last_b = 0;
    int          last_c = 0;
    int          err_len = 0;

    bulls_cows_core #(.MAX_ATTEMPTS(MAXA), .ERR_CYCLES(ERRC)) dut (
        .clock          (clock),
        .reset          (reset),
        .confirma       (confirma),
        .SW             (SW),
        .LED            (LED),
        .displaysResult (displaysResult)
    );

    always #5 clock = ~clock;
    assign disp_flat = displaysResult;

    function automatic logic [15:0] led_of(input int stbit, input int b, input int c);
        return 16'(1 << stbit) | 16'(((1 << c) - 1) << 4) | 16'((1 << b) - 1);
    endfunction

    function automatic logic [31:0] disp_of(input logic [15:0] g, input int att, input int b, input int c);
        return {g, 4'(att / 10), 4'(att % 10), 4'(b), 4'(c)};
    endfunction

    task automatic model_score(input logic [15:0] s, input logic [15:0] g, output int b, output int c);
        b = 0;
        c = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (g[4*i +: 4] == s[4*j +: 4]) begin
                    if (i == j) b++;
                    else c++;
                end
    endtask

    task automatic push_exp(input string tag, input logic [15:0] led, input logic [31:0] disp);
        exp_t e;
        e.tag  = tag;
        e.led  = led;
        e.disp = disp;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert (LED === e.led) else begin
            miscompares++;
            $error("FAIL %s LED observed=%h expected=%h", e.tag, LED, e.led);
        end
        vectors++;
        assert (disp_flat === e.disp) else begin
            miscompares++;
            $error("FAIL %s displays observed=%h expected=%h", e.tag, disp_flat, e.disp);
        end
    endtask

    task automatic press(input logic [15:0] v, input int hold);
        @(negedge clock);
        SW = v;
        confirma = 1'b1;
        repeat (hold) @(negedge clock);
        confirma = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic new_secret(input logic [15:0] v);
        press(v, 3);
        secret_m   = v;
        attempts_m = 0;
        last_g = 16'h0000; last_b = 0; last_c = 0;
        push_exp("secret", led_of(14, 0, 0), 32'h0);
        check_out();
    endtask

    task automatic guess_step(input string tag, input logic [15:0] g, input int hold);
        int b, c, st;
        press(g, hold);
        model_score(secret_m, g, b, c);
        attempts_m++;
        st = (b == 4) ? 13 : ((attempts_m == MAXA) ? 12 : 14);
        last_g = g; last_b = b; last_c = c;
        push_exp(tag, led_of(st, b, c), disp_of(g, attempts_m, b, c));
        check_out();
    endtask

    task automatic end_round();
        press(16'h1111, 3);
        attempts_m = 0;
        push_exp("to_secret", 16'h8000, 32'h0);
        check_out();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        push_exp("reset", 16'h8000, 32'h0);
        check_out();
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Basic round: partial score, held button, rejected guess
        new_secret(16'h1234);
        guess_step("g1243", 16'h1243, 3);
        guess_step("held50", 16'h5678, 50);
        press(16'h1123, 3);
        repeat (ERRC + 2) @(negedge clock);
        push_exp("bad_guess", led_of(14, last_b, last_c), disp_of(last_g, attempts_m, last_b, last_c));
        check_out();

        // Reach ten attempts, then lose on the twelfth
        guess_step("g2143", 16'h2143, 3);
        guess_step("g1235", 16'h1235, 3);
        guess_step("g4321", 16'h4321, 3);
        guess_step("g1342", 16'h1342, 3);
        guess_step("g5671", 16'h5671, 3);
        guess_step("g9abc", 16'h9ABC, 3);
        guess_step("g3214", 16'h3214, 3);
        guess_step("g0123", 16'h0123, 3);
        guess_step("gf0e1", 16'hF0E1, 3);
        guess_step("lose", 16'h5678, 3);
        end_round();

        // Immediate win
        new_secret(16'h1234);
        guess_step("win", 16'h1234, 3);
        end_round();

        // Win on the final attempt beats lose
        new_secret(16'hA5C3);
        for (int i = 0; i < MAXA - 1; i++) guess_step("miss", 16'h0124, 3);
        guess_step("last_win", 16'hA5C3, 3);
        end_round();

        // Error window length with a press inside it
        @(negedge clock);
        SW = 16'h1123;
        err_len = 0;
        for (int k = 0; k < 40; k++) begin
            confirma = (k < 2) || (k >= 4 && k < 6);
            if (LED[11]) err_len++;
            @(negedge clock);
        end
        confirma = 1'b0;
        vectors++;
        assert (err_len === ERRC) else begin
            miscompares++;
            $error("FAIL err_len observed=%0d expected=%0d", err_len, ERRC);
        end
        push_exp("after_err", 16'h8000, 32'h0);
        check_out();

        // Asynchronous reset while in S_CALC
        new_secret(16'h1234);
        @(negedge clock);
        SW = 16'h4321;
        confirma = 1'b1;
        repeat (3) @(negedge clock);
        push_exp("in_calc", led_of(14, 0, 0), disp_of(16'h4321, 0, 0, 0));
        check_out();
        #1 reset = 1'b0;
        confirma = 1'b0;
        #1;
        push_exp("rst_calc", 16'h8000, 32'h0);
        check_out();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Asynchronous reset while in S_ERR
        new_secret(16'h1234);
        guess_step("pre_err", 16'h1243, 3);
        @(negedge clock);
        SW = 16'h7777;
        confirma = 1'b1;
        repeat (2) @(negedge clock);
        confirma = 1'b0;
        repeat (3) @(negedge clock);
        push_exp("in_err", led_of(11, last_b, last_c), disp_of(last_g, attempts_m, last_b, last_c));
        check_out();
        #1 reset = 1'b0;
        #1;
        push_exp("rst_err", 16'h8000, 32'h0);
        check_out();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
